// File: rtl/spike_dispatcher_if.sv
// Packet ingress and router egress handshakes of the spike dispatcher.
// The slave modport is the dispatcher side; the master modport is the surrounding fabric.
interface spike_dispatcher_if #(
  parameter int ADDRESS_WIDTH = 12
);
  logic [2*ADDRESS_WIDTH-1:0] packet_in;
  logic                       packet_valid;
  logic                       packet_ready;
  logic [2*ADDRESS_WIDTH-1:0] forward_packet;
  logic                       forward_valid;
  logic                       forward_ready;

  modport master (
    output packet_in, packet_valid, forward_ready,
    input  packet_ready, forward_packet, forward_valid
  );

  modport slave (
    input  packet_in, packet_valid, forward_ready,
    output packet_ready, forward_packet, forward_valid
  );
endinterface

// File: rtl/spike_dispatcher.sv
// Buffers {origin, destination} spike packets and routes each one to a local neuron strobe,
// the drop counter, or the NoC router port. The FIFO head is classified and popped once per cycle.
module spike_dispatcher #(
  parameter int NUMBER_OF_NEURONS = 10,
  parameter int ADDRESS_WIDTH     = 12,
  parameter int BASE_ADDRESS      = 0,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                       CLK,
  input  logic                                       reset,
  spike_dispatcher_if.slave                          bus,
  output logic [NUMBER_OF_NEURONS*ADDRESS_WIDTH-1:0] source_addresses_out,
  output logic [NUMBER_OF_NEURONS-1:0]               source_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]            fifo_count,
  output logic [7:0]                                 dropped_count,
  output logic                                       overflow,
  output logic                                       idle
);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int PW    = 2 * ADDRESS_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [AW:0] LOCAL_LO = (AW+1)'(BASE_ADDRESS);
  localparam logic [AW:0] LOCAL_HI = (AW+1)'(BASE_ADDRESS + NUMBER_OF_NEURONS);

  typedef enum logic {IDLE, FWD_WAIT} state_t;

  state_t                                 state_q, state_d;
  logic [PW-1:0]                          mem_q [FIFO_DEPTH];
  logic [PW-1:0]                          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                       count_q, count_d;
  logic [NUMBER_OF_NEURONS*AW-1:0]        src_addr_q, src_addr_d;
  logic [NUMBER_OF_NEURONS-1:0]           src_valid_q, src_valid_d;
  logic [PW-1:0]                          fwd_pkt_q, fwd_pkt_d;
  logic                                   fwd_valid_q, fwd_valid_d;
  logic [7:0]                             dropped_q, dropped_d;
  logic                                   overflow_q, overflow_d;

  logic          full, push, pop;
  logic [PW-1:0] head;
  logic [AW-1:0] head_org, head_dst;
  logic [AW:0]   head_ext, head_off;
  logic          is_drop, is_local;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign full     = (count_q == FULL_COUNT);
  assign push     = bus.packet_valid && !full;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign head_org = head[PW-1:AW];
  assign head_dst = head[AW-1:0];
  assign head_ext = {1'b0, head_dst};
  assign head_off = head_ext - LOCAL_LO;
  assign is_drop  = (head_dst == {AW{1'b1}});
  assign is_local = (head_ext >= LOCAL_LO) && (head_ext < LOCAL_HI);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    src_addr_d  = src_addr_q;
    src_valid_d = '0;
    fwd_pkt_d   = fwd_pkt_q;
    fwd_valid_d = fwd_valid_q;
    dropped_d   = dropped_q;
    overflow_d  = overflow_q | (bus.packet_valid & full);

    if (push) begin
      mem_d[wr_ptr_q] = bus.packet_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // The null-connection marker wins over the local range check.
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (is_drop) begin
            if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
          end else if (is_local) begin
            for (int i = 0; i < NUMBER_OF_NEURONS; i++) begin
              if (head_off == (AW+1)'(i)) begin
                src_addr_d[i*AW +: AW] = head_org;
                src_valid_d[i]         = 1'b1;
              end
            end
          end else begin
            fwd_pkt_d   = head;
            fwd_valid_d = 1'b1;
            state_d     = FWD_WAIT;
          end
        end
      end
      FWD_WAIT: begin
        if (bus.forward_ready) begin
          fwd_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      src_addr_q  <= {NUMBER_OF_NEURONS*AW{1'b1}};
      src_valid_q <= '0;
      fwd_pkt_q   <= '0;
      fwd_valid_q <= 1'b0;
      dropped_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      src_addr_q  <= src_addr_d;
      src_valid_q <= src_valid_d;
      fwd_pkt_q   <= fwd_pkt_d;
      fwd_valid_q <= fwd_valid_d;
      dropped_q   <= dropped_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.packet_ready    = !full;
  assign bus.forward_packet  = fwd_pkt_q;
  assign bus.forward_valid   = fwd_valid_q;
  assign source_addresses_out = src_addr_q;
  assign source_valid        = src_valid_q;
  assign fifo_count          = count_q;
  assign dropped_count       = dropped_q;
  assign overflow            = overflow_q;
  assign idle                = (count_q == '0) && (state_q == IDLE) && (src_valid_q == '0);
endmodule

// File: doc/spike_dispatcher.md
Name: spike_dispatcher

Overview:
- Consumes 24-bit spike packets {origin[23:12], destination[11:0]} emitted by network_interface.
- Buffers them in a FIFO and delivers each origin address to the addressed local neuron's source_address input, one packet per cycle, with a one-cycle strobe.
- Hands packets for non-local destinations to the NoC router port through a valid/ready handshake.
- Sits between network_interface and the neuron array, replacing the behavioural packet-to-neuron routing.

Parameters:
- NUMBER_OF_NEURONS, 10: local neurons served; local index = destination - BASE_ADDRESS.
- ADDRESS_WIDTH, 12: neuron address width; packet width = 2*ADDRESS_WIDTH.
- BASE_ADDRESS, 0: address of local neuron 0.
- FIFO_DEPTH, 8: packet FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- packet_in  in  24  {origin, destination}.
- packet_valid  in  1  packet_in is valid this cycle.
- packet_ready  out  1  FIFO can accept a packet; a transfer occurs when packet_valid && packet_ready.
- source_addresses_out  out  NUMBER_OF_NEURONS*12  neuron i uses bits [12i+11:12i]; holds the last origin delivered to neuron i.
- source_valid  out  NUMBER_OF_NEURONS  one-hot, one-cycle strobe marking a new delivery.
- forward_packet  out  24  non-local packet to the router.
- forward_valid  out  1  forward_packet is valid.
- forward_ready  in  1  router accepts forward_packet.
- fifo_count  out  clog2(FIFO_DEPTH+1)  current occupancy.
- dropped_count  out  8  number of dropped packets; saturates at 255.
- overflow  out  1  sticky; set when packet_valid is high while the FIFO is full.
- idle  out  1  FIFO empty, state IDLE, no strobe pending.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next posedge:
  - FIFO emptied; pointers and fifo_count = 0.
  - source_addresses_out = all 12'hFFF; source_valid = 0.
  - forward_valid = 0; forward_packet = 0.
  - dropped_count = 0; overflow = 0.
  - state = IDLE.
  - Reset mid-operation discards all buffered and in-flight packets. A held forward_packet is abandoned with no handshake.
- Enqueue:
  - packet_ready = (fifo_count != FIFO_DEPTH), computed from registered state only. A pop in the same cycle gives no credit.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Classification of the FIFO head (combinational on head entry):
  - DROP: destination == 12'hFFF (null connection marker).
  - LOCAL: BASE_ADDRESS <= destination < BASE_ADDRESS + NUMBER_OF_NEURONS.
  - FORWARD: anything else.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head.
    - LOCAL: on the next posedge, source_addresses_out[idx] = origin and source_valid[idx] = 1 for exactly one cycle; stay in IDLE.
    - DROP: increment dropped_count (saturating); stay in IDLE.
    - FORWARD: load forward_packet, set forward_valid, go to FWD_WAIT.
  - FWD_WAIT: hold forward_packet and forward_valid stable until forward_ready is high at a posedge. Then clear forward_valid and return to IDLE. No pops occur while in FWD_WAIT.
- Throughput and latency:
  - One pop per cycle, so back-to-back LOCAL packets give back-to-back strobes.
  - No bypass: a packet accepted at edge N is popped at the earliest at edge N+1, with its strobe visible after edge N+1 (cycle N+1 to N+2).
  - Packets are delivered in arrival order. Two packets to the same neuron give two consecutive strobes; the later origin remains on the bus.
- The timestep clear is not an input. Packets queued across a timestep boundary are delivered in the next timestep.
- overflow clears only on reset. The rejected packet is not counted in dropped_count; the upstream block keeps it.
- idle = (fifo_count == 0) && state == IDLE && source_valid == 0.

Test Plan:
1. Reset then idle: assert reset for 2 cycles -> all source_addresses_out = 12'hFFF, source_valid = 0, fifo_count = 0, packet_ready = 1, idle = 1.
2. Local delivery: push {12'd1, 12'd4} at edge N -> source_valid = 10'b0000010000 for one cycle after edge N+1; neuron 4's field = 12'd1 and holds that value afterwards.
3. Burst and full:
   - push 9 packets back to back with the dispatcher stalled in FWD_WAIT (forward_ready = 0) -> packet_ready drops after 8 accepted, overflow = 1, fifo_count = 8.
   - raise forward_ready -> all packets drain in order, one per cycle.
4. Forward handshake: push {12'd3, 12'd42} with forward_ready low for 5 cycles -> forward_valid and forward_packet = 24'h00302A stable for 5 cycles, released on the first ready edge; a following local packet is strobed only after release.
5. Drop and saturation: push {12'd5, 12'hFFF} 300 times -> no strobes, dropped_count = 255.
6. Reset mid-burst: 4 packets queued, reset pulse -> fifo_count = 0, no further strobes, outputs at reset values.
